// File: rtl/ssb_tracking_ctrl.sv
// SSB tracking controller: steers the PSS detector between full search,
// correlator pause between SSBs, and a narrow FIND window around the next
// expected SSB for the locked N_id_2. Drops lock after a run of empty windows.
module ssb_tracking_ctrl #(
    parameter int SSB_INTERVAL    = 38400,
    parameter int TRACK_TOLERANCE = 100,
    parameter int MAX_MISSES      = 3,
    parameter int CNT_W           = $clog2(SSB_INTERVAL + TRACK_TOLERANCE + 1),
    parameter int MISS_W          = $clog2(MAX_MISSES + 1)
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              enable_i,
    input  logic              s_axis_in_tvalid,
    input  logic [1:0]        N_id_2_i,
    input  logic              N_id_2_valid_i,
    output logic [1:0]        mode_o,
    output logic [1:0]        requested_N_id_2_o,
    output logic              locked_o,
    output logic              ssb_found_o,
    output logic              lock_lost_o,
    output logic [MISS_W-1:0] miss_cnt_o,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  sample_cnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        PAUSE  = 2'd2,
        FIND   = 2'd3
    } state_t;

    localparam logic [1:0] MODE_SEARCH = 2'd0;
    localparam logic [1:0] MODE_FIND   = 2'd1;
    localparam logic [1:0] MODE_PAUSE  = 2'd2;

    // Last PAUSE count before the window opens, and last count inside the window.
    localparam logic [CNT_W-1:0]  PAUSE_END = CNT_W'(SSB_INTERVAL - TRACK_TOLERANCE - 1);
    localparam logic [CNT_W-1:0]  WIN_END   = CNT_W'(SSB_INTERVAL + TRACK_TOLERANCE - 1);
    // After a miss the counter is placed where the expected peak would have
    // been TRACK_TOLERANCE samples ago, so the next window stays centred.
    localparam logic [CNT_W-1:0]  REANCHOR  = CNT_W'(TRACK_TOLERANCE);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MAX_MISSES - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [MISS_W-1:0]  miss_nxt;
    logic               lock_nxt;
    logic [1:0]         req_nxt;
    logic               found_nxt;
    logic               lost_nxt;
    logic [1:0]         mode_nxt;
    logic               match;

    assign match   = N_id_2_valid_i && (N_id_2_i == requested_N_id_2_o);
    assign state_o = state;

    // Register state and every output; async reset returns all to idle values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state              <= IDLE;
            mode_o             <= MODE_PAUSE;
            requested_N_id_2_o <= 2'd0;
            locked_o           <= 1'b0;
            ssb_found_o        <= 1'b0;
            lock_lost_o        <= 1'b0;
            miss_cnt_o         <= '0;
            sample_cnt_o       <= '0;
        end else begin
            state              <= state_nxt;
            mode_o             <= mode_nxt;
            requested_N_id_2_o <= req_nxt;
            locked_o           <= lock_nxt;
            ssb_found_o        <= found_nxt;
            lock_lost_o        <= lost_nxt;
            miss_cnt_o         <= miss_nxt;
            sample_cnt_o       <= cnt_nxt;
        end
    end

    // Next-state and next-output logic; enable_i low overrides every event.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = sample_cnt_o;
        miss_nxt  = miss_cnt_o;
        lock_nxt  = locked_o;
        req_nxt   = requested_N_id_2_o;
        found_nxt = 1'b0;
        lost_nxt  = 1'b0;

        if (!enable_i) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            miss_nxt  = '0;
            lock_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = SEARCH;
                    cnt_nxt   = '0;
                    miss_nxt  = '0;
                    lock_nxt  = 1'b0;
                end
                SEARCH: begin
                    if (N_id_2_valid_i) begin
                        req_nxt   = N_id_2_i;
                        cnt_nxt   = '0;
                        miss_nxt  = '0;
                        found_nxt = 1'b1;
                        state_nxt = PAUSE;
                    end
                end
                PAUSE: begin
                    if (s_axis_in_tvalid) begin
                        cnt_nxt = sample_cnt_o + CNT_W'(1);
                        if (sample_cnt_o == PAUSE_END) state_nxt = FIND;
                    end
                end
                FIND: begin
                    if (match) begin
                        cnt_nxt   = '0;
                        miss_nxt  = '0;
                        lock_nxt  = 1'b1;
                        found_nxt = 1'b1;
                        state_nxt = PAUSE;
                    end else if (s_axis_in_tvalid) begin
                        if (sample_cnt_o == WIN_END) begin
                            if (miss_cnt_o == MISS_LAST) begin
                                lock_nxt  = 1'b0;
                                miss_nxt  = '0;
                                lost_nxt  = 1'b1;
                                cnt_nxt   = '0;
                                state_nxt = SEARCH;
                            end else begin
                                miss_nxt  = miss_cnt_o + MISS_W'(1);
                                cnt_nxt   = REANCHOR;
                                state_nxt = PAUSE;
                            end
                        end else begin
                            cnt_nxt = sample_cnt_o + CNT_W'(1);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        case (state_nxt)
            SEARCH:  mode_nxt = MODE_SEARCH;
            FIND:    mode_nxt = MODE_FIND;
            default: mode_nxt = MODE_PAUSE;
        endcase
    end

endmodule

// File: tb/tb_ssb_tracking_ctrl.sv
// Directed bench for ssb_tracking_ctrl with a short SSB period:
// acquisition, tracking at window edges, mismatches, misses, disable, reset.
module tb_ssb_tracking_ctrl;

    localparam int SSB  = 200;
    localparam int TOL  = 10;
    localparam int MISS = 2;
    localparam int CW   = $clog2(SSB + TOL + 1);
    localparam int MW   = $clog2(MISS + 1);

    logic          clk_i = 1'b0;
    logic          clk_en = 1'b1;
    logic          reset_ni;
    logic          enable_i;
    logic          s_axis_in_tvalid;
    logic [1:0]    N_id_2_i;
    logic          N_id_2_valid_i;
    logic [1:0]    mode_o;
    logic [1:0]    requested_N_id_2_o;
    logic          locked_o;
    logic          ssb_found_o;
    logic          lock_lost_o;
    logic [MW-1:0] miss_cnt_o;
    logic [1:0]    state_o;
    logic [CW-1:0] sample_cnt_o;

    int n_chk  = 0;
    int n_pass = 0;

    ssb_tracking_ctrl #(
        .SSB_INTERVAL(SSB),
        .TRACK_TOLERANCE(TOL),
        .MAX_MISSES(MISS)
    ) dut (
        .clk_i(clk_i),
        .reset_ni(reset_ni),
        .enable_i(enable_i),
        .s_axis_in_tvalid(s_axis_in_tvalid),
        .N_id_2_i(N_id_2_i),
        .N_id_2_valid_i(N_id_2_valid_i),
        .mode_o(mode_o),
        .requested_N_id_2_o(requested_N_id_2_o),
        .locked_o(locked_o),
        .ssb_found_o(ssb_found_o),
        .lock_lost_o(lock_lost_o),
        .miss_cnt_o(miss_cnt_o),
        .state_o(state_o),
        .sample_cnt_o(sample_cnt_o)
    );

    always begin
        #5;
        if (clk_en) clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_peak(input logic [1:0] n);
        N_id_2_i       = n;
        N_id_2_valid_i = 1'b1;
        step();
        N_id_2_valid_i = 1'b0;
    endtask

    // Step until the sample counter shows target, bounded.
    task automatic run_to(input int target);
        int n;
        n = 0;
        while (int'(sample_cnt_o) != target && n < 400) begin
            step();
            n++;
        end
        chk("reach_cnt", int'(sample_cnt_o), target);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"}, state_o, 0);
        chk({tag, "_mode"}, mode_o, 2);
        chk({tag, "_req"}, requested_N_id_2_o, 0);
        chk({tag, "_locked"}, locked_o, 0);
        chk({tag, "_found"}, ssb_found_o, 0);
        chk({tag, "_lost"}, lock_lost_o, 0);
        chk({tag, "_miss"}, miss_cnt_o, 0);
        chk({tag, "_cnt"}, sample_cnt_o, 0);
    endtask

    initial begin
        reset_ni         = 1'b0;
        enable_i         = 1'b0;
        s_axis_in_tvalid = 1'b0;
        N_id_2_i         = 2'd0;
        N_id_2_valid_i   = 1'b0;
        repeat (3) step();
        check_reset_vals("rst");
        reset_ni = 1'b1;
        step();

        // Acquisition
        enable_i         = 1'b1;
        s_axis_in_tvalid = 1'b1;
        step();
        chk("search_state", state_o, 1);
        chk("search_mode", mode_o, 0);
        do_peak(2'd2);
        chk("acq_found", ssb_found_o, 1);
        chk("acq_req", requested_N_id_2_o, 2);
        chk("acq_mode", mode_o, 2);
        chk("acq_locked", locked_o, 0);
        chk("acq_cnt", sample_cnt_o, 0);
        step();
        chk("acq_found_pulse", ssb_found_o, 0);
        repeat (188) step();
        chk("pause_189_mode", mode_o, 2);
        chk("pause_189_cnt", sample_cnt_o, 189);
        step();
        chk("find_open_mode", mode_o, 1);
        chk("find_open_cnt", sample_cnt_o, 190);

        // Tracking: match at 200, then window edges
        run_to(200);
        do_peak(2'd2);
        chk("trk_locked", locked_o, 1);
        chk("trk_cnt", sample_cnt_o, 0);
        chk("trk_mode", mode_o, 2);
        chk("trk_miss", miss_cnt_o, 0);
        for (int p = 0; p < 5; p++) begin
            run_to((p % 2 == 0) ? 191 : 209);
            chk("trk_in_find", mode_o, 1);
            do_peak(2'd2);
            chk("trk_found", ssb_found_o, 1);
            chk("trk_cnt0", sample_cnt_o, 0);
            chk("trk_miss0", miss_cnt_o, 0);
            chk("trk_state", state_o, 2);
        end

        // Non-matching peak inside window is ignored
        run_to(195);
        do_peak(2'd1);
        chk("mm_found", ssb_found_o, 0);
        chk("mm_state", state_o, 3);
        chk("mm_cnt", sample_cnt_o, 196);
        run_to(200);
        do_peak(2'd2);
        chk("mm_then_match", ssb_found_o, 1);

        // First empty window
        run_to(209);
        step();
        chk("miss1_cnt", miss_cnt_o, 1);
        chk("miss1_sample", sample_cnt_o, 10);
        chk("miss1_mode", mode_o, 2);
        chk("miss1_locked", locked_o, 1);
        chk("miss1_lost", lock_lost_o, 0);
        repeat (179) step();
        chk("miss1_pause_mode", mode_o, 2);
        step();
        chk("miss1_reopen_mode", mode_o, 1);
        chk("miss1_reopen_cnt", sample_cnt_o, 190);

        // Second empty window -> unlock
        run_to(209);
        step();
        chk("unlock_lost", lock_lost_o, 1);
        chk("unlock_locked", locked_o, 0);
        chk("unlock_mode", mode_o, 0);
        chk("unlock_miss", miss_cnt_o, 0);
        chk("unlock_state", state_o, 1);
        step();
        chk("unlock_pulse", lock_lost_o, 0);

        // Disable while locked in FIND
        do_peak(2'd0);
        run_to(200);
        do_peak(2'd0);
        chk("dis_pre_locked", locked_o, 1);
        run_to(195);
        chk("dis_pre_state", state_o, 3);
        enable_i = 1'b0;
        step();
        chk("dis_state", state_o, 0);
        chk("dis_mode", mode_o, 2);
        chk("dis_locked", locked_o, 0);
        chk("dis_lost", lock_lost_o, 0);
        chk("dis_cnt", sample_cnt_o, 0);

        // Asynchronous reset mid-PAUSE with the clock held
        enable_i = 1'b1;
        step();
        do_peak(2'd3);
        run_to(200);
        do_peak(2'd3);
        repeat (5) step();
        chk("prerst_locked", locked_o, 1);
        chk("prerst_cnt", sample_cnt_o, 5);
        chk("prerst_req", requested_N_id_2_o, 3);
        clk_en = 1'b0;
        #2;
        reset_ni = 1'b0;
        #1;
        check_reset_vals("async_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ssb_tracking_ctrl.md
# ssb_tracking_ctrl

Sequences the PSS detector across the SSB timeline. It drives the detector's `mode_i` and `requested_N_id_2_i` inputs.
- Starts in full SEARCH.
- After the first PSS hit, it PAUSEs the correlators until a window of ±TRACK_TOLERANCE samples around the next expected SSB, then runs FIND for the locked N_id_2 in that window.
- Declares loss of lock after MAX_MISSES consecutive empty windows and falls back to SEARCH.

It sits between the PSS detector outputs and its mode inputs, and saves correlator power between SSBs.

## Interface
- SSB_INTERVAL, 38400, SSB period in input samples (20 ms at 1.92 Msps).
- TRACK_TOLERANCE, 100, half-width of the FIND window in samples; 1 ≤ TRACK_TOLERANCE < SSB_INTERVAL/2.
- MAX_MISSES, 3, consecutive missed windows before unlock; ≥1.
- CNT_W, $clog2(SSB_INTERVAL+TRACK_TOLERANCE+1), sample counter width (derived).
- clk_i  in  1  clock.
- reset_ni  in  1  reset, asynchronous, active-low.
- enable_i  in  1  run tracking; low forces IDLE.
- s_axis_in_tvalid  in  1  sample strobe; each high cycle is one sample.
- N_id_2_i  in  2  N_id_2 reported by the detector.
- N_id_2_valid_i  in  1  detector peak-valid pulse.
- mode_o  out  2  detector mode: 0 SEARCH, 1 FIND, 2 PAUSE.
- requested_N_id_2_o  out  2  N_id_2 requested in FIND.
- locked_o  out  1  tracking lock.
- ssb_found_o  out  1  one-cycle pulse on an accepted peak.
- lock_lost_o  out  1  one-cycle pulse on unlock.
- miss_cnt_o  out  $clog2(MAX_MISSES+1)  current consecutive misses.
- state_o  out  2  FSM state: 0 IDLE, 1 SEARCH, 2 PAUSE, 3 FIND.
- sample_cnt_o  out  CNT_W  samples since the last accepted peak.

## Operation
- A "peak" is N_id_2_valid_i high in a cycle.
- A "match" is a peak with N_id_2_i == requested_N_id_2_o.
- All outputs are registered. mode_o always follows the next state: IDLE→2, SEARCH→0, PAUSE→2, FIND→1.
- **IDLE:** cnt=0, misses=0, locked=0. On enable_i → SEARCH.
- **SEARCH:** on any peak:
  - requested_N_id_2_o<=N_id_2_i, cnt<=0, misses<=0, ssb_found_o pulse.
  - → PAUSE.
  - locked_o is not set.
- **PAUSE:**
  - Each strobe increments cnt.
  - A strobe with cnt==SSB_INTERVAL-TRACK_TOLERANCE-1 → FIND.
  - Peaks are ignored.
- **FIND:**
  - Each strobe increments cnt.
  - On a match: cnt<=0, misses<=0, locked_o<=1, ssb_found_o pulse, → PAUSE.
  - Non-matching peaks are ignored.
  - A strobe with cnt==SSB_INTERVAL+TRACK_TOLERANCE-1 and no match in that cycle is a miss. Then:
    - If misses+1==MAX_MISSES: locked_o<=0, misses<=0, lock_lost_o pulse, cnt<=0, → SEARCH.
    - Otherwise: misses<=misses+1, cnt<=TRACK_TOLERANCE (re-anchors to the expected peak position), → PAUSE.
- Simultaneous match and window-end strobe: the match wins; no miss is counted.
- enable_i low in any state → IDLE next cycle. This has priority over all events. locked_o clears with no lock_lost_o pulse.
- The counter never exceeds SSB_INTERVAL+TRACK_TOLERANCE-1. In SEARCH and IDLE it holds its value and does not count.

## Timing
- Reset values:
  - state IDLE.
  - mode_o=2, requested_N_id_2_o=0.
  - locked_o=0, ssb_found_o=0, lock_lost_o=0.
  - miss_cnt_o=0, sample_cnt_o=0.
- One-cycle latency from event (peak, strobe, enable_i edge) to the updated state, mode_o and pulses.
- The FIND window covers counts SSB_INTERVAL-TRACK_TOLERANCE … SSB_INTERVAL+TRACK_TOLERANCE-1, i.e. 2·TRACK_TOLERANCE samples.
- The detector registers mode internally. Peaks arriving the cycle after a transition are judged by the new state.
- Reset asserted mid-operation immediately clears all state and outputs. No pulse is generated.

## Test plan
Parameters: SSB_INTERVAL=200, TRACK_TOLERANCE=10, MAX_MISSES=2, continuous strobes.
- **Acquisition:** enable, peak with N_id_2=2 → next cycle: ssb_found_o=1, requested_N_id_2_o=2, mode_o=2, locked_o=0.
  - mode_o=1 exactly 190 strobes after the peak.
- **Tracking:** a match at count 200 → locked_o=1, sample_cnt_o=0, mode_o=2, miss_cnt_o=0.
  - Repeat for 5 periods, with matches at counts 191 and 209 → every one accepted.
- **Mismatch/edge:**
  - A peak with N_id_2=1 in FIND is ignored.
  - A match on the same cycle as the count-209 strobe is accepted, not counted as a miss.
- **Misses:**
  - One empty window → miss_cnt_o=1, sample_cnt_o=10, mode_o=2, locked_o stays 1; the next window opens 180 strobes later.
  - A second empty window → lock_lost_o pulse, locked_o=0, mode_o=0.
- **Control/reset:**
  - enable_i low in FIND → IDLE, mode_o=2, locked_o=0, no lock_lost_o.
  - reset_ni low mid-PAUSE with the clock stopped → all outputs return to reset values at once.
